// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_unit_if.sv
// Word-aligned memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, legality check
// and load lane select/extension of the captured read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_funct3_i,
    input  logic [1:0]  req_off_i,
    input  logic        req_store_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        err_o,
    input  logic [2:0]  rsp_funct3_i,
    input  logic [1:0]  rsp_off_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rsp_data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = req_wdata_i;
        err_o   = 1'b0;
        case (req_funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << req_off_i;
                wdata_o = {4{req_wdata_i[7:0]}};
            end
            F3_H, F3_HU: begin
                be_o    = 4'b0011 << req_off_i;
                wdata_o = {2{req_wdata_i[15:0]}};
                err_o   = req_off_i[0];
            end
            F3_W: begin
                be_o  = 4'b1111;
                err_o = (req_off_i != 2'b00);
            end
            default: err_o = 1'b1;
        endcase
        // Unsigned variants exist only for loads.
        if (req_store_i && req_funct3_i[2]) begin
            err_o = 1'b1;
        end
    end

    always_comb begin
        lane_h = rsp_off_i[1] ? rsp_rdata_i[31:16] : rsp_rdata_i[15:0];
        lane_b = rsp_off_i[0] ? lane_h[15:8] : lane_h[7:0];
        case (rsp_funct3_i)
            F3_B:    rsp_data_o = {{24{lane_b[7]}}, lane_b};
            F3_BU:   rsp_data_o = {24'h0, lane_b};
            F3_H:    rsp_data_o = {{16{lane_h[15]}}, lane_h};
            F3_HU:   rsp_data_o = {16'h0, lane_h};
            F3_W:    rsp_data_o = rsp_rdata_i;
            default: rsp_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: one bus transaction per access, stalling the pipeline
// until ack. Define LSU_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic [2:0]        funct3M,
    input  logic [31:0]       Mem_WrAddr,
    input  logic [31:0]       Mem_WrData,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    load_store_unit_if.master bus,
    output logic              lsu_err
);

    if (TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d, lsu_err_q, lsu_err_d;

    logic        access, align_err, start, bad_req, timeout;
    logic [3:0]  req_be;
    logic [31:0] req_wdata, rsp_data;

    // A simultaneous read and write is a store, so MemWriteM alone selects direction.
    assign access  = MemWriteM | MemReadM;
    assign start   = (state_q == StIdle) && access && !align_err;
    assign bad_req = (state_q == StIdle) && access && align_err;

    lsu_align u_align (
        .req_funct3_i (funct3M),
        .req_off_i    (Mem_WrAddr[1:0]),
        .req_store_i  (MemWriteM),
        .req_wdata_i  (Mem_WrData),
        .be_o         (req_be),
        .wdata_o      (req_wdata),
        .err_o        (align_err),
        .rsp_funct3_i (f3_q),
        .rsp_off_i    (off_q),
        .rsp_rdata_i  (rdata_q),
        .rsp_data_o   (rsp_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == StWait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == StWait) && !bus.bus_ack &&
                     (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StWait;
            StWait: if (bus.bus_ack || timeout) state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        StallM      = start || (state_q == StWait);
        bus.bus_req = (state_q == StWait);
        ReadDataM   = 32'h0;
        if ((state_q == StResp) && !we_q) begin
            ReadDataM = rsp_data;
        end
    end

    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        we_d      = we_q;
        f3_d      = f3_q;
        off_d     = off_q;
        rdata_d   = rdata_q;
        lsu_err_d = bad_req || timeout;
        if (start) begin
            addr_d  = {Mem_WrAddr[31:2], 2'b00};
            wdata_d = req_wdata;
            be_d    = req_be;
            we_d    = MemWriteM;
            f3_d    = funct3M;
            off_d   = Mem_WrAddr[1:0];
        end
        if ((state_q == StWait) && bus.bus_ack) begin
            rdata_d = bus.bus_rdata;
        end else if (timeout) begin
            rdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            we_q      <= 1'b0;
            f3_q      <= 3'h0;
            off_q     <= 2'h0;
            rdata_q   <= 32'h0;
            lsu_err_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            rdata_q   <= rdata_d;
            lsu_err_q <= lsu_err_d;
        end
    end

    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_be    = be_q;
    assign lsu_err       = lsu_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit; build with LSU_TIMEOUT_EN to cover the abort path.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TimeoutCycles = 4;
    localparam int          LongWait      = 3;
`else
    localparam int unsigned TimeoutCycles = 255;
    localparam int          LongWait      = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM, MemReadM;
    logic [2:0]  funct3M;
    logic [31:0] Mem_WrAddr, Mem_WrData, ReadDataM;
    logic        StallM, lsu_err;

    load_store_unit_if bus_if ();

    load_store_unit #(
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .funct3M    (funct3M),
        .Mem_WrAddr (Mem_WrAddr),
        .Mem_WrData (Mem_WrData),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .bus        (bus_if),
        .lsu_err    (lsu_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] result;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [31:0] rdata);
        exp_t        m;
        int          n;
        int          off;
        logic [31:0] sh;
        off     = int'(addr[1:0]);
        n       = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        m.we    = we;
        m.addr  = {addr[31:2], 2'b00};
        m.be    = 4'(((1 << n) - 1) << off);
        m.wdata = 32'h0;
        for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = data[8*(i % n) +: 8];
        sh = rdata >> (8 * off);
        if (we)          m.result = 32'h0;
        else if (n == 4) m.result = rdata;
        else if (n == 2) m.result = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        else             m.result = f3[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        return m;
    endfunction

    task automatic run_access(input string tag, input logic we, input logic re,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] rdata,
                              input int ack_wait);
        exp_t got;
        int   waits = 0, stalls = 0, errs = 0;
        bit   acked = 0, done = 0;
        sb_q.push_back(model(we, f3, addr, data, rdata));
        MemWriteM = we; MemReadM = re; funct3M = f3; Mem_WrAddr = addr; Mem_WrData = data;
        for (int cyc = 0; cyc < ack_wait + 8 && !done; cyc++) begin
            @(negedge clk);
            errs += int'(lsu_err);
            if (acked) begin
                check_eq({tag, "_stall_resp"}, StallM, 0);
                check_eq({tag, "_req_drop"}, bus_if.bus_req, 0);
                check_eq({tag, "_rdata"}, ReadDataM, got.result);
                done = 1;
            end else begin
                stalls += int'(StallM);
                check_eq({tag, "_rdata_zero"}, ReadDataM, 0);
                if (bus_if.bus_req) begin
                    waits++;
                    bus_if.bus_ack   = (waits == ack_wait);
                    bus_if.bus_rdata = bus_if.bus_ack ? rdata : $urandom();
                    if (bus_if.bus_ack) begin
                        check_eq({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 1);
                        if (sb_q.size() != 0) begin
                            got = sb_q.pop_front();
                            check_eq({tag, "_we"}, bus_if.bus_we, got.we);
                            check_eq({tag, "_be"}, bus_if.bus_be, got.be);
                            check_eq({tag, "_addr"}, bus_if.bus_addr, got.addr);
                            if (got.we) check_eq({tag, "_wdata"}, bus_if.bus_wdata, got.wdata);
                        end
                        acked = 1;
                    end
                end
            end
            @(posedge clk);
            #1;
            bus_if.bus_ack = 1'b0;
        end
        check_eq({tag, "_resp_seen"}, 32'(done), 1);
        check_eq({tag, "_stall_cycles"}, stalls, ack_wait + 1);
        check_eq({tag, "_no_err"}, errs, 0);
        MemWriteM = 1'b0; MemReadM = 1'b0;
        @(negedge clk);
        check_eq({tag, "_rdata_idle"}, ReadDataM, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_bad(input string tag, input logic we, input logic re,
                           input logic [2:0] f3, input logic [31:0] addr);
        int errs = 0, reqs = 0, stalls = 0;
        MemWriteM = we; MemReadM = re; funct3M = f3; Mem_WrAddr = addr; Mem_WrData = $urandom();
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            errs   += int'(lsu_err);
            reqs   += int'(bus_if.bus_req);
            stalls += int'(StallM);
            check_eq({tag, "_rdata"}, ReadDataM, 0);
            @(posedge clk);
            #1;
            MemWriteM = 1'b0; MemReadM = 1'b0;
        end
        check_eq({tag, "_err_pulses"}, errs, 1);
        check_eq({tag, "_reqs"}, reqs, 0);
        check_eq({tag, "_stalls"}, stalls, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0]  lf3[5];
        logic [2:0]  f3;
        logic [31:0] a;
        int          reqs;
        bit          seen;
        lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        reset = 1'b0;
        MemWriteM = 1'b0; MemReadM = 1'b0; funct3M = 3'h0; Mem_WrAddr = 32'h0; Mem_WrData = 32'h0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_req", bus_if.bus_req, 0);
        check_eq("rst_we", bus_if.bus_we, 0);
        check_eq("rst_be", bus_if.bus_be, 0);
        check_eq("rst_addr", bus_if.bus_addr, 0);
        check_eq("rst_wdata", bus_if.bus_wdata, 0);
        check_eq("rst_err", lsu_err, 0);
        check_eq("rst_rdata", ReadDataM, 0);
        check_eq("rst_stall", StallM, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_access("sw_100", 1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
        run_access("lb_103", 0, 1, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1);
        run_access("lbu_103", 0, 1, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1);
        run_access("sh_102", 1, 0, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1);
        run_access("lh_102", 0, 1, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 2);
        run_access("lhu_000", 0, 1, 3'b101, 32'h0, 32'h0, 32'h1234_F00D, 1);
        run_access("sb_101", 1, 0, 3'b000, 32'h101, 32'h0000005A, 32'h0, 2);
        run_access("lw_long", 0, 1, 3'b010, 32'h104, 32'h0, 32'hCAFE_0001, LongWait);
        run_access("rw_both", 1, 1, 3'b010, 32'h108, 32'h1357_9BDF, 32'hFFFF_FFFF, 1);

        for (int i = 0; i < 6; i++) begin
            f3 = lf3[$urandom_range(4)];
            a  = $urandom() & ~((f3[1:0] == 2'd2) ? 32'h3 : (f3[1:0] == 2'd1) ? 32'h1 : 32'h0);
            run_access("rnd_ld", 0, 1, f3, a, 32'h0, $urandom(), $urandom_range(1, 3));
            f3 = lf3[$urandom_range(2)];
            a  = $urandom() & ~((f3[1:0] == 2'd2) ? 32'h3 : (f3[1:0] == 2'd1) ? 32'h1 : 32'h0);
            run_access("rnd_st", 1, 0, f3, a, $urandom(), 32'h0, $urandom_range(1, 3));
        end

        run_bad("lw_101", 0, 1, 3'b010, 32'h101);
        run_bad("sh_103", 1, 0, 3'b001, 32'h103);
        run_bad("ld_f3_011", 0, 1, 3'b011, 32'h100);
        run_bad("st_f3_100", 1, 0, 3'b100, 32'h100);

        // Stray ack while idle must not start or complete anything.
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
        @(negedge clk);
        check_eq("ack_idle_req", bus_if.bus_req, 0);
        check_eq("ack_idle_stall", StallM, 0);
        check_eq("ack_idle_rdata", ReadDataM, 0);
        @(posedge clk);
        #1;
        bus_if.bus_ack = 1'b0;

        // Reset pulled low in WAIT abandons the access.
        MemReadM = 1'b1; funct3M = 3'b010; Mem_WrAddr = 32'h300;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("rstw_in_wait", bus_if.bus_req, 1);
        reset = 1'b0;
        #1;
        check_eq("rstw_req", bus_if.bus_req, 0);
        check_eq("rstw_be", bus_if.bus_be, 0);
        check_eq("rstw_addr", bus_if.bus_addr, 0);
        MemReadM = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        reqs = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            reqs += int'(bus_if.bus_req) + int'(StallM);
            @(posedge clk);
            #1;
        end
        check_eq("rstw_no_retry", reqs, 0);

`ifdef LSU_TIMEOUT_EN
        MemReadM = 1'b1; funct3M = 3'b010; Mem_WrAddr = 32'h200;
        reqs = 0;
        seen = 0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            if (lsu_err) begin
                seen = 1;
                check_eq("to_rdata", ReadDataM, 0);
                check_eq("to_stall", StallM, 0);
                check_eq("to_req", bus_if.bus_req, 0);
            end else begin
                reqs += int'(bus_if.bus_req);
            end
            @(posedge clk);
            #1;
        end
        MemReadM = 1'b0;
        check_eq("to_seen", 32'(seen), 1);
        check_eq("to_wait_cycles", reqs, TimeoutCycles);
        @(negedge clk);
        check_eq("to_err_pulse", lsu_err, 0);
        @(posedge clk);
        #1;
`endif

        check_eq("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
